// File: rtl/wb_tracker_pkg.sv
// Shared writeback/issue definitions: slot geometry, slot entry layout and unit encoding.
// Latency: n/a (types and constants only); no backpressure.
package wb_tracker_pkg;

    localparam int WB_DATA_W    = 64;
    localparam int WB_REG_AW    = 5;
    localparam int WB_MAX_DELAY = 7;
    localparam int WB_DELAY_W   = 3;
    localparam int WB_CNT_W     = 3;
    localparam int WB_NUM_UNITS = 3;

    typedef struct packed {
        logic                 valid;
        logic [WB_REG_AW-1:0] rd;
    } slot_t;

    // Encoding doubles as priority rank: a larger value wins when several units strobe.
    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_ADD = 2'd1,
        UNIT_MUL = 2'd2
    } unit_e;

    function automatic unit_e pick_unit(input logic [WB_NUM_UNITS-1:0] strobes);
        pick_unit = UNIT_ALU;
        for (int u = 0; u < WB_NUM_UNITS; u++) begin
            if (strobes[u]) begin
                pick_unit = unit_e'(2'(u));
            end
        end
    endfunction

endpackage

// File: rtl/wb_pending_cnt.sv
// Per-register saturating in-flight counters with one increment, two decrement ports and a 3-way query.
// Latency: counts update at the clock edge, query is combinational; no backpressure.
module wb_pending_cnt
    import wb_tracker_pkg::*;
#(
    parameter int REG_AW = WB_REG_AW,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic [REG_AW-1:0] inc_addr,
    input  logic              dec_a,
    input  logic [REG_AW-1:0] dec_a_addr,
    input  logic              dec_b,
    input  logic [REG_AW-1:0] dec_b_addr,
    input  logic [REG_AW-1:0] q_a,
    input  logic [REG_AW-1:0] q_b,
    input  logic [REG_AW-1:0] q_c,
    output logic              busy
);

    localparam int NREG    = 1 << REG_AW;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];

    // Net delta per register so that an increment and a decrement on the same
    // register cancel instead of one winning.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            int v;
            v = int'(cnt[i]);
            if (inc && (inc_addr == REG_AW'(i))) begin
                v = v + 1;
            end
            if (dec_a && (dec_a_addr == REG_AW'(i))) begin
                v = v - 1;
            end
            if (dec_b && (dec_b_addr == REG_AW'(i))) begin
                v = v - 1;
            end
            if (v < 0) begin
                v = 0;
            end
            if (v > CNT_MAX) begin
                v = CNT_MAX;
            end
            cnt_nxt[i] = CNT_W'(v);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign busy = (cnt[q_a] != '0) || (cnt[q_b] != '0) || (cnt[q_c] != '0);

endmodule

// File: rtl/wb_tracker.sv
// Tracks issued destinations in a delay-indexed slot ring and writes the promised unit result to the register file.
// Latency: result sampled issue+delay, rf write one cycle later; no backpressure, protocol faults raise err_* pulses.
module wb_tracker
    import wb_tracker_pkg::*;
#(
    parameter int DATA_W    = WB_DATA_W,
    parameter int REG_AW    = WB_REG_AW,
    parameter int MAX_DELAY = WB_MAX_DELAY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_v,
    input  logic [REG_AW-1:0]     issue_rd,
    input  logic [WB_DELAY_W-1:0] issue_delay,
    input  logic [REG_AW-1:0]     q_ra,
    input  logic [REG_AW-1:0]     q_rb,
    input  logic [REG_AW-1:0]     q_rd,
    output logic                  rd_conflict,
    input  logic                  alu_v,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  add_v,
    input  logic [DATA_W-1:0]     add_data,
    input  logic                  mul_v,
    input  logic [DATA_W-1:0]     mul_data,
    output logic                  rf_we,
    output logic [REG_AW-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  err_missing,
    output logic                  err_multi,
    output logic                  err_orphan,
    output logic                  err_slot,
    output logic                  err_delay
);

    slot_t slot     [MAX_DELAY];
    slot_t shifted  [MAX_DELAY];
    slot_t slot_nxt [MAX_DELAY];
    slot_t victim;

    logic bad_delay;
    logic issue_ok;
    logic collide;

    always_comb begin
        for (int k = 0; k < MAX_DELAY - 1; k++) begin
            shifted[k] = slot[k + 1];
        end
        shifted[MAX_DELAY-1] = '0;

        bad_delay = issue_v && ((issue_delay == '0) || (int'(issue_delay) > MAX_DELAY));
        issue_ok  = issue_v && !bad_delay;

        victim   = '0;
        slot_nxt = shifted;
        // The new entry lands after the shift, so any occupant it displaces is
        // the entry that would otherwise have moved into that position.
        if (issue_ok) begin
            victim = shifted[issue_delay - WB_DELAY_W'(1)];
            slot_nxt[issue_delay - WB_DELAY_W'(1)] = '{valid: 1'b1, rd: issue_rd};
        end
        collide = issue_ok && victim.valid;
    end

    logic [WB_NUM_UNITS-1:0] strobes;
    logic                    any_strobe;
    logic                    multi_strobe;
    logic                    retire;
    unit_e                   sel_unit;
    logic [DATA_W-1:0]       sel_data;

    assign strobes      = {mul_v, add_v, alu_v};
    assign any_strobe   = |strobes;
    assign multi_strobe = (alu_v && add_v) || (alu_v && mul_v) || (add_v && mul_v);
    assign retire       = slot[0].valid;
    assign sel_unit     = pick_unit(strobes);

    always_comb begin
        case (sel_unit)
            UNIT_MUL: sel_data = mul_data;
            UNIT_ADD: sel_data = add_data;
            default:  sel_data = alu_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                slot[k] <= '0;
            end
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            err_missing <= 1'b0;
            err_multi   <= 1'b0;
            err_orphan  <= 1'b0;
            err_slot    <= 1'b0;
            err_delay   <= 1'b0;
        end else begin
            slot  <= slot_nxt;
            rf_we <= retire && any_strobe;
            if (retire && any_strobe) begin
                rf_waddr <= slot[0].rd;
                rf_wdata <= sel_data;
            end
            err_missing <= retire && !any_strobe;
            err_multi   <= retire && multi_strobe;
            err_orphan  <= !retire && any_strobe;
            err_slot    <= collide;
            err_delay   <= bad_delay;
        end
    end

    logic cnt_busy;

    wb_pending_cnt #(
        .REG_AW (REG_AW),
        .CNT_W  (WB_CNT_W)
    ) u_pending (
        .clk        (clk),
        .reset      (reset),
        .inc        (issue_ok),
        .inc_addr   (issue_rd),
        .dec_a      (retire),
        .dec_a_addr (slot[0].rd),
        .dec_b      (collide),
        .dec_b_addr (victim.rd),
        .q_a        (q_ra),
        .q_b        (q_rb),
        .q_c        (q_rd),
        .busy       (cnt_busy)
    );

    // The counter has already dropped while the write is still in the rf_we stage.
    assign rd_conflict = cnt_busy ||
                         (rf_we && ((q_ra == rf_waddr) || (q_rb == rf_waddr) || (q_rd == rf_waddr)));

endmodule

// File: tb/tb_wb_tracker.sv
// Scenario bench for wb_tracker: scoreboard of expected register-file writes plus per-scenario pulse checks.
module tb_wb_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_v;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_delay;
    logic [4:0]  q_ra, q_rb, q_rd;
    logic        rd_conflict;
    logic        alu_v, add_v, mul_v;
    logic [63:0] alu_data, add_data, mul_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        err_missing, err_multi, err_orphan, err_slot, err_delay;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    wb_tracker dut (
        .clk         (clk),
        .reset       (reset),
        .issue_v     (issue_v),
        .issue_rd    (issue_rd),
        .issue_delay (issue_delay),
        .q_ra        (q_ra),
        .q_rb        (q_rb),
        .q_rd        (q_rd),
        .rd_conflict (rd_conflict),
        .alu_v       (alu_v),
        .alu_data    (alu_data),
        .add_v       (add_v),
        .add_data    (add_data),
        .mul_v       (mul_v),
        .mul_data    (mul_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .err_missing (err_missing),
        .err_multi   (err_multi),
        .err_orphan  (err_orphan),
        .err_slot    (err_slot),
        .err_delay   (err_delay)
    );

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && rf_we) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got addr %0d data %0h, required no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data)
                    $display("FAIL sb_write: got addr %0d data %0h, required addr %0d data %0h",
                             rf_waddr, rf_wdata, e.addr, e.data);
                else
                    passed++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_v = 0; issue_rd = 0; issue_delay = 0;
        alu_v = 0; add_v = 0; mul_v = 0;
        alu_data = 0; add_data = 0; mul_data = 0;
        q_ra = 0; q_rb = 0; q_rd = 0;
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b required 0", rf_we); else passed++;
        total++; if (rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr: got %0d required 0", rf_waddr); else passed++;
        total++; if (rf_wdata !== 64'd0) $display("FAIL reset_rf_wdata: got %0h required 0", rf_wdata); else passed++;
        total++;
        if ({err_missing, err_multi, err_orphan, err_slot, err_delay} !== 5'b0)
            $display("FAIL reset_errs: got %b required 00000",
                     {err_missing, err_multi, err_orphan, err_slot, err_delay});
        else passed++;
        for (int r = 0; r < 32; r += 5) begin
            q_ra = 5'(r); q_rb = 5'(r + 1); q_rd = 5'(r + 2);
            #1;
            total++; if (rd_conflict !== 1'b0) $display("FAIL reset_conflict_r%0d: got %b required 0", r, rd_conflict); else passed++;
        end
        tick();
    endtask

    task automatic test_basic();
        idle();
        q_ra = 5; q_rb = 20; q_rd = 21;
        issue_v = 1; issue_rd = 5; issue_delay = 3;
        #1;
        total++; if (rd_conflict !== 1'b0) $display("FAIL basic_conflict_issue_cycle: got %b required 0", rd_conflict); else passed++;
        tick(); issue_v = 0;
        total++; if (rd_conflict !== 1'b1) $display("FAIL basic_conflict_t1: got %b required 1", rd_conflict); else passed++;
        tick();
        total++; if (rd_conflict !== 1'b1) $display("FAIL basic_conflict_t2: got %b required 1", rd_conflict); else passed++;
        tick(); mul_v = 1; mul_data = 64'hAB; expect_write(5, 64'hAB);
        total++; if (rd_conflict !== 1'b1) $display("FAIL basic_conflict_t3: got %b required 1", rd_conflict); else passed++;
        tick(); mul_v = 0;
        total++; if (rf_we !== 1'b1) $display("FAIL basic_rf_we: got %b required 1", rf_we); else passed++;
        total++; if (rf_waddr !== 5'd5) $display("FAIL basic_rf_waddr: got %0d required 5", rf_waddr); else passed++;
        total++; if (rf_wdata !== 64'hAB) $display("FAIL basic_rf_wdata: got %0h required ab", rf_wdata); else passed++;
        total++; if (rd_conflict !== 1'b1) $display("FAIL basic_conflict_t4: got %b required 1", rd_conflict); else passed++;
        total++; if ({err_missing, err_multi, err_orphan} !== 3'b0) $display("FAIL basic_errs: got %b required 000", {err_missing, err_multi, err_orphan}); else passed++;
        tick();
        total++; if (rd_conflict !== 1'b0) $display("FAIL basic_conflict_t5: got %b required 0", rd_conflict); else passed++;
        total++; if (rf_we !== 1'b0) $display("FAIL basic_rf_we_drop: got %b required 0", rf_we); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        issue_v = 1; issue_rd = 2; issue_delay = 1;
        tick();
        issue_rd = 3; issue_delay = 1;
        alu_v = 1; alu_data = 64'h2222; expect_write(2, 64'h2222);
        tick();
        issue_v = 0;
        alu_data = 64'h3333; expect_write(3, 64'h3333);
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2) $display("FAIL b2b_first: got we %b addr %0d required we 1 addr 2", rf_we, rf_waddr); else passed++;
        tick();
        alu_v = 0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) $display("FAIL b2b_second: got we %b addr %0d required we 1 addr 3", rf_we, rf_waddr); else passed++;
        total++;
        if ({err_missing, err_multi, err_orphan, err_slot, err_delay} !== 5'b0)
            $display("FAIL b2b_errs: got %b required 00000", {err_missing, err_multi, err_orphan, err_slot, err_delay});
        else passed++;
        tick();
        total++; if (rf_we !== 1'b0) $display("FAIL b2b_idle: got %b required 0", rf_we); else passed++;
        tick();
    endtask

    task automatic test_slot_collision();
        idle();
        issue_v = 1; issue_rd = 7; issue_delay = 2;
        tick();
        issue_rd = 8; issue_delay = 1;
        tick();
        issue_v = 0;
        add_v = 1; add_data = 64'h88; expect_write(8, 64'h88);
        q_ra = 7; q_rb = 7; q_rd = 7;
        #1;
        total++; if (err_slot !== 1'b1) $display("FAIL slot_err_pulse: got %b required 1", err_slot); else passed++;
        total++; if (rd_conflict !== 1'b0) $display("FAIL slot_victim_count: got %b required 0", rd_conflict); else passed++;
        q_rb = 8;
        #1;
        total++; if (rd_conflict !== 1'b1) $display("FAIL slot_survivor_count: got %b required 1", rd_conflict); else passed++;
        tick();
        add_v = 0;
        total++; if (err_slot !== 1'b0) $display("FAIL slot_err_single: got %b required 0", err_slot); else passed++;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8) $display("FAIL slot_write: got we %b addr %0d required we 1 addr 8", rf_we, rf_waddr); else passed++;
        tick();
        tick();
    endtask

    task automatic test_missing_orphan();
        idle();
        q_ra = 9; q_rb = 9; q_rd = 9;
        issue_v = 1; issue_rd = 9; issue_delay = 1;
        tick();
        issue_v = 0;
        tick();
        total++; if (err_missing !== 1'b1) $display("FAIL missing_pulse: got %b required 1", err_missing); else passed++;
        total++; if (rf_we !== 1'b0) $display("FAIL missing_no_write: got %b required 0", rf_we); else passed++;
        total++; if (rd_conflict !== 1'b0) $display("FAIL missing_count: got %b required 0", rd_conflict); else passed++;
        alu_v = 1; alu_data = 64'hDEAD;
        tick();
        alu_v = 0;
        total++; if (err_orphan !== 1'b1) $display("FAIL orphan_pulse: got %b required 1", err_orphan); else passed++;
        total++; if (err_missing !== 1'b0) $display("FAIL missing_single: got %b required 0", err_missing); else passed++;
        total++; if (rf_we !== 1'b0) $display("FAIL orphan_no_write: got %b required 0", rf_we); else passed++;
        tick();
        total++; if (err_orphan !== 1'b0) $display("FAIL orphan_single: got %b required 0", err_orphan); else passed++;
    endtask

    task automatic test_multi();
        idle();
        issue_v = 1; issue_rd = 10; issue_delay = 2;
        tick();
        issue_v = 0;
        tick();
        add_v = 1; add_data = 64'h11; mul_v = 1; mul_data = 64'h22; expect_write(10, 64'h22);
        tick();
        idle();
        total++; if (err_multi !== 1'b1) $display("FAIL multi_pulse_mul_add: got %b required 1", err_multi); else passed++;
        total++; if (rf_wdata !== 64'h22) $display("FAIL multi_data_mul_add: got %0h required 22", rf_wdata); else passed++;
        issue_v = 1; issue_rd = 11; issue_delay = 1;
        tick();
        issue_v = 0;
        alu_v = 1; alu_data = 64'h33; add_v = 1; add_data = 64'h44; expect_write(11, 64'h44);
        tick();
        idle();
        total++; if (err_multi !== 1'b1) $display("FAIL multi_pulse_add_alu: got %b required 1", err_multi); else passed++;
        total++; if (rf_wdata !== 64'h44 || rf_waddr !== 5'd11) $display("FAIL multi_data_add_alu: got addr %0d data %0h required addr 11 data 44", rf_waddr, rf_wdata); else passed++;
        tick();
        total++; if (err_multi !== 1'b0) $display("FAIL multi_single: got %b required 0", err_multi); else passed++;
    endtask

    task automatic test_reset_midflight();
        idle();
        issue_v = 1; issue_rd = 12; issue_delay = 5;
        tick();
        issue_rd = 13; issue_delay = 6;
        tick();
        issue_rd = 14; issue_delay = 7;
        tick();
        q_ra = 12; q_rb = 12; q_rd = 12;
        issue_rd = 15; issue_delay = 1;
        reset = 1;
        #1;
        total++; if (rd_conflict !== 1'b1) $display("FAIL midrst_inflight: got %b required 1", rd_conflict); else passed++;
        tick();
        reset = 0; issue_v = 0;
        q_ra = 12; q_rb = 13; q_rd = 14;
        #1;
        total++; if (rd_conflict !== 1'b0) $display("FAIL midrst_conflict: got %b required 0", rd_conflict); else passed++;
        q_ra = 15; q_rb = 15; q_rd = 15;
        #1;
        total++; if (rd_conflict !== 1'b0) $display("FAIL midrst_issue_dropped: got %b required 0", rd_conflict); else passed++;
        tick();
        total++; if (err_missing !== 1'b0) $display("FAIL midrst_no_missing: got %b required 0", err_missing); else passed++;
        alu_v = 1; alu_data = 64'h1;
        tick();
        alu_v = 0;
        total++; if (err_orphan !== 1'b1 || rf_we !== 1'b0) $display("FAIL midrst_orphan_a: got orphan %b we %b required 1 0", err_orphan, rf_we); else passed++;
        tick();
        mul_v = 1; mul_data = 64'h2;
        tick();
        mul_v = 0;
        total++; if (err_orphan !== 1'b1 || rf_we !== 1'b0) $display("FAIL midrst_orphan_b: got orphan %b we %b required 1 0", err_orphan, rf_we); else passed++;
        tick();
    endtask

    task automatic test_delay0();
        idle();
        q_ra = 16; q_rb = 16; q_rd = 16;
        issue_v = 1; issue_rd = 16; issue_delay = 0;
        tick();
        issue_v = 0;
        total++; if (err_delay !== 1'b1) $display("FAIL delay0_pulse: got %b required 1", err_delay); else passed++;
        total++; if (rd_conflict !== 1'b0) $display("FAIL delay0_conflict: got %b required 0", rd_conflict); else passed++;
        tick();
        total++; if (err_delay !== 1'b0) $display("FAIL delay0_single: got %b required 0", err_delay); else passed++;
        total++; if (err_missing !== 1'b0) $display("FAIL delay0_no_entry: got %b required 0", err_missing); else passed++;
        tick();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_slot_collision();
        test_missing_orphan();
        test_multi();
        test_reset_midflight();
        test_delay0();
        tick();
        total++; if (exp_q.size() != 0) $display("FAIL sb_drained: got %0d outstanding required 0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_tracker.md
# wb_tracker

Writeback-side counterpart of the issue hazard logic: records every issued instruction's destination register and writeback delay, then at the promised cycle collects the result from the ALU, add or multiply unit and drives the register-file write port. It also owns per-register in-flight counts and produces the `rd_conflict` signal consumed by the issue stage. Protocol violations (missing, duplicate or orphan results, slot collisions) are flagged as one-cycle error pulses.

## Interface
- `DATA_W`, default 64: result / register-file data width.
- `REG_AW`, default 5: register address width (32 registers).
- `MAX_DELAY`, default 7: largest legal writeback delay; also the slot count.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `issue_v`  in  1  instruction issued this cycle (issue-stage `issue_ok`).
- `issue_rd`  in  REG_AW  destination register of the issued instruction.
- `issue_delay`  in  3  cycles from issue to result; legal range 1..MAX_DELAY.
- `q_ra`, `q_rb`, `q_rd`  in  REG_AW each  registers of the instruction at issue, checked for pending writes.
- `rd_conflict`  out  1  combinational; any queried register has a write in flight.
- `alu_v` / `alu_data`, `add_v` / `add_data`, `mul_v` / `mul_data`  in  1 / DATA_W  unit result strobes and data.
- `rf_we`  out  1  registered register-file write enable.
- `rf_waddr`  out  REG_AW  registered write address.
- `rf_wdata`  out  DATA_W  registered write data.
- `err_missing`, `err_multi`, `err_orphan`, `err_slot`, `err_delay`  out  1 each  registered one-cycle error pulses.

## Operation
- Slot ring: entries `slot[0..MAX_DELAY-1]`, each holding {valid, rd}. `slot[0]` is the result expected in the current cycle.
- Every clock edge, `slot[k] <= slot[k+1]` and the top slot is cleared.
- Issue with `issue_v=1` and delay d in 1..MAX_DELAY writes {1, issue_rd} into `slot[d-1]` after the shift.
  - If the post-shift occupant is valid, the new entry overwrites it and `err_slot` pulses.
  - Delay 0 is ignored: no entry, no count change, and `err_delay` pulses.
- Retire, each cycle while `slot[0].valid`:
  - Exactly one unit strobe: data goes to `rf_wdata`, `slot[0].rd` goes to `rf_waddr`, `rf_we=1` next cycle.
  - No strobe: `err_missing` pulses and no write occurs.
  - More than one strobe: `err_multi` pulses and the highest-priority unit is written; priority is mul > add > alu.
- Any strobe while `slot[0]` is invalid: `err_orphan` pulses and the data is dropped.
- Pending counters: 3-bit count per register.
  - Incremented on an accepted issue to that register.
  - Decremented when `slot[0].valid` retires, with or without error.
  - Simultaneous increment and decrement on the same register: no change.
  - An overwritten entry (`err_slot`) decrements its own register's count.
  - Counts saturate at 0 and 7.
- `rd_conflict = 1` when any of `q_ra`, `q_rb`, `q_rd`:
  - has a count ≠ 0, or
  - equals `rf_waddr` while `rf_we=1`, which covers the cycle in which the register-file write is still landing.
- Register 0 gets no special treatment.

## Timing
- Issue at cycle t with delay d: result is sampled at cycle t+d, `rf_we` is high at cycle t+d+1, and the register-file contents update at the edge ending t+d+1.
- `rd_conflict` is combinational from the counters, the `rf_we` stage and the query inputs; there is no same-cycle path from `issue_v`.
- On reset:
  - all slots invalid, all counters 0;
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`;
  - all `err_*` = 0.
- Reset mid-operation discards every in-flight entry; results arriving afterward raise `err_orphan`.
- Reset has priority over issue and retire in the same cycle.
- Back-to-back retires produce consecutive `rf_we` cycles with no bubble.

## Structure
- Shared package holds:
  - `MAX_DELAY` and the default data/address widths;
  - the slot entry struct {valid, rd};
  - the unit-select encoding (ALU=0, ADD=1, MUL=2) and its priority order.
- The same package is imported by the issue stage, so reservation depth and slot count stay consistent.
- Sub-module `wb_pending_cnt`: array of per-register saturating counters with inc/dec ports and a three-address query.
- Slot ring, retire mux and error logic stay in `wb_tracker`.

## Test plan
- Issue rd=5, delay=3 at cycle 10; `mul_v=1`, data=0xAB at cycle 13 → `rf_we=1`, `rf_waddr=5`, `rf_wdata=0xAB` at cycle 14; `rd_conflict` with `q_ra=5` is high during cycles 11–14 and low at cycle 15.
- Issue rd=2 delay=1 and, next cycle, rd=3 delay=1; ALU strobes at consecutive cycles → two consecutive writes (2, 3) with no errors.
- Issue delay=2, then delay=1 one cycle later, so both target the same slot → `err_slot` pulses once; only the second rd is written; counter for the first rd returns to 0.
- Slot valid with no strobes → `err_missing` pulses, `rf_we` stays 0, counter decrements to 0. Strobe with no slot → `err_orphan`.
- `add_v` and `mul_v` both high on a valid slot, with data 0x11 / 0x22 → `err_multi` pulses, written data = 0x22.
- Three issues in flight, then `reset` → next cycle all counters 0 and `rd_conflict=0`; later strobes each raise `err_orphan`. Issue with delay 0 → `err_delay` pulses and no conflict appears.
